mioc_gate_test_seq: RTL and testbench

//  On-chip pattern sequencer for the MIOC gate-under-test (and2-nor nmos cell, inputs in1..in4, output z).

---
 rtl/mioc_gate_test_seq_pkg.sv | 21 ++
 rtl/mioc_gate_test_seq_settle_timer.sv | 28 ++
 rtl/mioc_gate_test_seq.sv | 168 ++++++++++++++++
 tb/tb_mioc_gate_test_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mioc_gate_test_seq_pkg.sv
// Shared definitions for the MIOC gate test sequencer: FSM state encoding,
// default golden truth table and a truth-table lookup helper.
package mioc_gate_test_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_REPORT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // z = ~((in1 & in2) | in3 | in4), indexed by {in1,in2,in3,in4}
    localparam logic [15:0] EXP_TRUTH_DEFAULT = 16'h0111;

    function automatic logic truth_bit(input logic [15:0] table_bits, input logic [3:0] pat);
        return table_bits[pat];
    endfunction

endpackage

// File: rtl/mioc_gate_test_seq_settle_timer.sv
// Loadable down-counter timing the settle window between driving a pattern
// and sampling the gate output.
module mioc_gate_test_seq_settle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mioc_gate_test_seq.sv
// Pattern sequencer for the MIOC gate-under-test: sweeps a 4-bit pattern range,
// samples z after a settle time, checks it against a golden table and streams results.
module mioc_gate_test_seq
    import mioc_gate_test_seq_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] EXP_TRUTH     = EXP_TRUTH_DEFAULT,
    parameter int          CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  first_pat,
    input  logic [3:0]  last_pat,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    input  logic        z,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_pat,
    output logic        res_z,
    output logic        res_err,
    output logic [15:0] sampled_vec,
    output logic [4:0]  err_cnt,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  dbg_state
);

    // Timer is loaded with SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES clocks.
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cur;
    logic [3:0] last_q;
    logic [3:0] pat_q;

    logic accept_start;
    logic tmr_load;
    logic tmr_en;
    logic tmr_expired;
    logic do_sample;
    logic do_handshake;
    logic sample_err;

    mioc_gate_test_seq_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Result handshake: res_valid rises after SAMPLE and res_* stay frozen until
    // a cycle with res_valid && res_ready; that cycle is the single transfer.
    always_comb begin
        state_nx     = state;
        accept_start = 1'b0;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        do_sample    = 1'b0;
        do_handshake = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_nx     = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                tmr_load = 1'b1;
                state_nx = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_expired) begin
                    state_nx = ST_SAMPLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                do_sample = 1'b1;
                state_nx  = ST_REPORT;
            end
            ST_REPORT: begin
                if (res_valid && res_ready) begin
                    do_handshake = 1'b1;
                    state_nx     = (cur == last_q) ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign sample_err = z ^ truth_bit(EXP_TRUTH, cur);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= '0;
            last_q      <= '0;
            pat_q       <= '0;
            res_valid   <= 1'b0;
            res_pat     <= '0;
            res_z       <= 1'b0;
            res_err     <= 1'b0;
            sampled_vec <= '0;
            err_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (accept_start) begin
                cur         <= first_pat;
                last_q      <= last_pat;
                busy        <= 1'b1;
                done        <= 1'b0;
                err_cnt     <= '0;
                sampled_vec <= '0;
            end
            if (state == ST_DRIVE) begin
                pat_q <= cur;
            end
            if (do_sample) begin
                res_valid        <= 1'b1;
                res_pat          <= cur;
                res_z            <= z;
                res_err          <= sample_err;
                sampled_vec[cur] <= z;
                err_cnt          <= err_cnt + 5'(sample_err);
            end
            if (do_handshake) begin
                res_valid <= 1'b0;
                if (cur == last_q) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cur <= cur + 4'd1;
                end
            end
        end
    end

    // Pins keep the last pattern after the sweep so the cell stays in a known state.
    assign {in1, in2, in3, in4} = pat_q;
    assign pass      = done && (err_cnt == 5'd0);
    assign dbg_state = state;

endmodule

// File: tb/tb_mioc_gate_test_seq.sv
// Self-checking bench for mioc_gate_test_seq: behavioural gate model, expected
// result queue built from the sweep rules, and directed sweeps.
module tb_mioc_gate_test_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  first_pat;
    logic [3:0]  last_pat;
    logic        in1, in2, in3, in4;
    logic        z;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_pat;
    logic        res_z;
    logic        res_err;
    logic [15:0] sampled_vec;
    logic [4:0]  err_cnt;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic force_zero = 1'b0;

    logic [5:0] exp_q[$];
    logic [3:0] obs_pat_q[$];
    logic       obs_z_q[$];
    int         hs_count;
    int         hs_cycle;
    int         stall_seen;
    logic [3:0] last_stall_pins;
    logic       prev_hold;
    logic [5:0] hold_snap;
    logic [15:0] exp_vec;
    int          exp_errs;

    logic       stall_armed = 1'b0;
    logic [3:0] stall_pat   = 4'd0;
    int         stall_len   = 0;

    mioc_gate_test_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .first_pat   (first_pat),
        .last_pat    (last_pat),
        .in1         (in1),
        .in2         (in2),
        .in3         (in3),
        .in4         (in4),
        .z           (z),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_pat     (res_pat),
        .res_z       (res_z),
        .res_err     (res_err),
        .sampled_vec (sampled_vec),
        .err_cnt     (err_cnt),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural gate cell
    function automatic logic gate_z(input logic [3:0] p);
        return ~((p[3] & p[2]) | p[1] | p[0]);
    endfunction

    assign z = force_zero ? 1'b0 : gate_z({in1, in2, in3, in4});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // expected results for a sweep: wrap-around range, z from the model, err vs gate function
    task automatic build_model(input logic [3:0] f, input logic [3:0] l, input logic f0);
        logic [3:0] p;
        logic       mz;
        exp_q.delete();
        exp_vec  = '0;
        exp_errs = 0;
        p = f;
        for (int i = 0; i < 16; i++) begin
            mz = f0 ? 1'b0 : gate_z(p);
            exp_q.push_back({p, mz, mz != gate_z(p)});
            exp_vec[p] = mz;
            if (mz != gate_z(p)) exp_errs++;
            if (p == l) break;
            p = p + 4'd1;
        end
    endtask

    // scoreboard / compare process
    always @(negedge clk) begin
        logic [5:0] e;
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", res_valid, 1'b1);
                check("hold_res", {res_pat, res_z, res_err}, hold_snap);
            end
            if (res_valid) check("pins_match_res", {in1, in2, in3, in4}, res_pat);
            if (res_valid && res_ready) begin
                hs_count++;
                hs_cycle = cyc;
                obs_pat_q.push_back(res_pat);
                obs_z_q.push_back(res_z);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=none", res_pat);
                end else begin
                    e = exp_q.pop_front();
                    check("res_pat", res_pat, e[5:2]);
                    check("res_z", res_z, e[1]);
                    check("res_err", res_err, e[0]);
                end
            end
            if (res_valid && !res_ready) begin
                stall_seen++;
                last_stall_pins = {in1, in2, in3, in4};
            end
            prev_hold = res_valid && !res_ready;
            hold_snap = {res_pat, res_z, res_err};
        end
    end

    // logger ready driver with optional stall on one pattern
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_armed && res_valid && res_pat == stall_pat) begin
                res_ready = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
                res_ready   = 1'b1;
                stall_armed = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [3:0] f, input logic [3:0] l);
        @(posedge clk);
        #1;
        first_pat = f;
        last_pat  = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input logic f0,
                             output int lat);
        int n;
        force_zero = f0;
        build_model(f, l, f0);
        hs_count   = 0;
        stall_seen = 0;
        obs_pat_q.delete();
        obs_z_q.delete();
        pulse_start(f, l);
        lat = 1;
        while (!res_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout actual=notdone required=done");
        end else begin
            check("done_after_hs", cyc - hs_cycle, 1);
            check("busy_at_done", busy, 1'b0);
            check("hs_count", hs_count, exp_q.size() + obs_pat_q.size() - exp_q.size());
            check("exp_q_drained", exp_q.size(), 0);
            check("err_cnt", err_cnt, exp_errs);
            check("sampled_vec", sampled_vec, exp_vec);
            check("pass", pass, exp_errs == 0);
        end
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        start     = 1'b0;
        first_pat = 4'd0;
        last_pat  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {in1, in2, in3, in4, res_valid, res_pat, res_z, res_err, sampled_vec,
               err_cnt, busy, done, pass}, 0);
        check("reset_state", dbg_state, 3'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // full sweep against the good gate
        run_sweep(4'd0, 4'd15, 1'b0, lat);
        check("t1_first_latency", lat, 7);
        check("t1_handshakes", hs_count, 16);
        check("t1_vec_literal", sampled_vec, 16'h0111);
        check("t1_errs_literal", err_cnt, 5'd0);
        check("t1_pass_literal", pass, 1'b1);

        // stuck-at-0 output: errors on patterns 0, 4, 8
        run_sweep(4'd0, 4'd15, 1'b1, lat);
        check("t2_errs_literal", err_cnt, 5'd3);
        check("t2_pass_literal", pass, 1'b0);
        check("t2_vec_literal", sampled_vec, 16'h0000);

        // wrapping range
        run_sweep(4'd14, 4'd1, 1'b0, lat);
        check("t3_handshakes", hs_count, 4);
        if (obs_pat_q.size() == 4) begin
            check("t3_order0", obs_pat_q[0], 4'd14);
            check("t3_order1", obs_pat_q[1], 4'd15);
            check("t3_order2", obs_pat_q[2], 4'd0);
            check("t3_order3", obs_pat_q[3], 4'd1);
        end

        // single pattern
        run_sweep(4'd5, 4'd5, 1'b0, lat);
        check("t4_handshakes", hs_count, 1);
        if (obs_pat_q.size() == 1) begin
            check("t4_pat", obs_pat_q[0], 4'd5);
            check("t4_z", obs_z_q[0], 1'b0);
        end
        check("t4_done", done, 1'b1);

        // backpressure on pattern 2
        stall_pat   = 4'd2;
        stall_len   = 10;
        stall_armed = 1'b1;
        run_sweep(4'd0, 4'd3, 1'b0, lat);
        check("t5_stall_cycles", stall_seen, 10);
        check("t5_stall_pins", last_stall_pins, 4'b0010);
        check("t5_handshakes", hs_count, 4);

        // reset in the middle of SETTLE for pattern 7
        build_model(4'd7, 4'd9, 1'b0);
        hs_count = 0;
        pulse_start(4'd7, 4'd9);
        for (int i = 0; i < 50 && {in1, in2, in3, in4} != 4'd7; i++) begin
            @(posedge clk);
            #1;
        end
        check("t6_pins_before_reset", {in1, in2, in3, in4}, 4'd7);
        @(posedge clk);
        #1;
        check("t6_in_settle", dbg_state, 3'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_reset_outputs",
              {in1, in2, in3, in4, res_valid, res_pat, res_z, res_err, sampled_vec,
               err_cnt, busy, done, pass}, 0);
        check("t6_reset_state", dbg_state, 3'd0);
        check("t6_no_result", hs_count, 0);
        reset = 1'b0;
        exp_q.delete();

        // clean sweep after the abort, with a start pulse while busy
        fork
            run_sweep(4'd0, 4'd3, 1'b0, lat);
            begin
                repeat (4) @(posedge clk);
                #1;
                check("t6_busy_on_restart", busy, 1'b1);
                first_pat = 4'd10;
                last_pat  = 4'd12;
                start     = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        check("t6_handshakes", hs_count, 4);
        if (obs_pat_q.size() == 4) check("t6_last_pat", obs_pat_q[3], 4'd3);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
